// File: rtl/mux_arb_pkg.sv
// Shared constants, state type and helpers for the mux round-robin arbiter.
package mux_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [0:0] {
    IDLE,
    GRANT
  } arb_state_t;

  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit after the pointer, with wrap.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   pointer,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset down so the nearest candidate is assigned last and wins.
  always_comb begin
    any  = 1'b0;
    idx  = pointer;
    cand = pointer;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = pointer + SEL_W'(i);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux; grants are held until released.
// Optional hold timeout is enabled by defining MUX_ARB_HOLD_TIMEOUT_EN.
module mux_rr_arbiter
  import mux_arb_pkg::*;
`ifdef MUX_ARB_HOLD_TIMEOUT_EN
#(
  parameter int unsigned MAX_HOLD = 8
)
`endif
(
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic [NUM_REQ-1:0] i_Req,
  input  logic               i_Done,
  output logic [NUM_REQ-1:0] o_Grant,
  output logic [SEL_W-1:0]   o_Select,
  output logic               o_Valid
);

  arb_state_t         state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [SEL_W-1:0]   select_q;
  logic               valid_q;
  logic [SEL_W-1:0]   ptr_q;

  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;
  logic [SEL_W-1:0]   owner_idx;
  logic               release_c;

  rr_pick u_rr_pick (
    .req     (i_Req),
    .pointer (ptr_q),
    .any     (pick_any),
    .idx     (pick_idx)
  );

  assign owner_idx = onehot_to_idx(grant_q);

`ifdef MUX_ARB_HOLD_TIMEOUT_EN
  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt_q;
  logic       others_pending;
  logic       timeout_c;

  assign others_pending = |(i_Req & ~grant_q);
  assign timeout_c      = others_pending && (hold_cnt_q == HoldLast);
  assign release_c      = i_Done | ~i_Req[owner_idx] | timeout_c;
`else
  assign release_c      = i_Done | ~i_Req[owner_idx];
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      select_q   <= '0;
      valid_q    <= 1'b0;
      ptr_q      <= SEL_W'(NUM_REQ - 1);
`ifdef MUX_ARB_HOLD_TIMEOUT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q    <= GRANT;
            grant_q    <= NUM_REQ'(1) << pick_idx;
            select_q   <= pick_idx;
            valid_q    <= 1'b1;
            ptr_q      <= pick_idx;
`ifdef MUX_ARB_HOLD_TIMEOUT_EN
            hold_cnt_q <= '0;
`endif
          end
        end
        GRANT: begin
          // Select is left untouched on release so the mux input does not glitch.
          if (release_c) begin
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
          end
`ifdef MUX_ARB_HOLD_TIMEOUT_EN
          else if (others_pending) begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
`endif
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_Grant  = grant_q;
  assign o_Select = select_q;
  assign o_Valid  = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter using an expected-output scoreboard queue.
module tb_mux_rr_arbiter;

  logic       i_Clk;
  logic       i_Rst;
  logic [3:0] i_Req;
  logic       i_Done;
  logic [3:0] o_Grant;
  logic [1:0] o_Select;
  logic       o_Valid;

  typedef struct {
    logic [3:0] g;
    logic [1:0] s;
    logic       v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mux_rr_arbiter dut (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Req    (i_Req),
    .i_Done   (i_Done),
    .o_Grant  (o_Grant),
    .o_Select (o_Select),
    .o_Valid  (o_Valid)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // Apply inputs away from the edge, then sample just after the next rising edge.
  task automatic cyc(input logic rst, input logic [3:0] req, input logic done);
    @(negedge i_Clk);
    i_Rst  = rst;
    i_Req  = req;
    i_Done = done;
    @(posedge i_Clk);
    #1;
  endtask

  task automatic test_reset;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{g: 4'b0000, s: 2'd0, v: 1'b0});
      cyc(1'b1, 4'b1111, 1'b1);
      e = sb.pop_front();
      checks++;
      if ({o_Grant, o_Select, o_Valid} !== {e.g, e.s, e.v}) begin
        errors++;
        $display("FAIL reset[%0d]: got g=%b s=%0d v=%b want g=%b s=%0d v=%b",
                 i, o_Grant, o_Select, o_Valid, e.g, e.s, e.v);
      end
    end
  endtask

  task automatic test_first_grant;
    logic [3:0] reqs[3] = '{4'b0110, 4'b0000, 4'b0000};
    exp_t e;
    sb.push_back('{g: 4'b0010, s: 2'd1, v: 1'b1});
    sb.push_back('{g: 4'b0000, s: 2'd1, v: 1'b0});
    sb.push_back('{g: 4'b0000, s: 2'd1, v: 1'b0});
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, reqs[i], 1'b0);
      e = sb.pop_front();
      checks++;
      if ({o_Grant, o_Select, o_Valid} !== {e.g, e.s, e.v}) begin
        errors++;
        $display("FAIL first_grant[%0d]: got g=%b s=%0d v=%b want g=%b s=%0d v=%b",
                 i, o_Grant, o_Select, o_Valid, e.g, e.s, e.v);
      end
    end
  endtask

  task automatic test_round_robin;
    exp_t e;
    cyc(1'b1, 4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      for (int ph = 0; ph < 2; ph++) begin
        if (ph == 0) sb.push_back('{g: 4'b0001 << (k % 4), s: 2'(k % 4), v: 1'b1});
        else         sb.push_back('{g: 4'b0000, s: 2'(k % 4), v: 1'b0});
        cyc(1'b0, 4'b1111, (ph == 1));
        e = sb.pop_front();
        checks++;
        if ({o_Grant, o_Select, o_Valid} !== {e.g, e.s, e.v}) begin
          errors++;
          $display("FAIL round_robin[%0d.%0d]: got g=%b s=%0d v=%b want g=%b s=%0d v=%b",
                   k, ph, o_Grant, o_Select, o_Valid, e.g, e.s, e.v);
        end
      end
    end
  endtask

  task automatic test_owner_drop;
    logic [3:0] reqs[5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    exp_t e;
    for (int i = 0; i < 3; i++) sb.push_back('{g: 4'b0100, s: 2'd2, v: 1'b1});
    for (int i = 0; i < 2; i++) sb.push_back('{g: 4'b0000, s: 2'd2, v: 1'b0});
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, reqs[i], 1'b0);
      e = sb.pop_front();
      checks++;
      if ({o_Grant, o_Select, o_Valid} !== {e.g, e.s, e.v}) begin
        errors++;
        $display("FAIL owner_drop[%0d]: got g=%b s=%0d v=%b want g=%b s=%0d v=%b",
                 i, o_Grant, o_Select, o_Valid, e.g, e.s, e.v);
      end
    end
  endtask

  task automatic test_done_idle;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{g: 4'b0000, s: 2'd2, v: 1'b0});
      cyc(1'b0, 4'b0000, 1'b1);
      e = sb.pop_front();
      checks++;
      if ({o_Grant, o_Select, o_Valid} !== {e.g, e.s, e.v}) begin
        errors++;
        $display("FAIL done_idle[%0d]: got g=%b s=%0d v=%b want g=%b s=%0d v=%b",
                 i, o_Grant, o_Select, o_Valid, e.g, e.s, e.v);
      end
    end
  endtask

  task automatic test_reset_mid_grant;
    logic       rsts[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] reqs[4] = '{4'b1000, 4'b1000, 4'b1001, 4'b0000};
    exp_t e;
    sb.push_back('{g: 4'b1000, s: 2'd3, v: 1'b1});
    sb.push_back('{g: 4'b0000, s: 2'd0, v: 1'b0});
    sb.push_back('{g: 4'b0001, s: 2'd0, v: 1'b1});
    sb.push_back('{g: 4'b0000, s: 2'd0, v: 1'b0});
    for (int i = 0; i < 4; i++) begin
      cyc(rsts[i], reqs[i], 1'b0);
      e = sb.pop_front();
      checks++;
      if ({o_Grant, o_Select, o_Valid} !== {e.g, e.s, e.v}) begin
        errors++;
        $display("FAIL reset_mid_grant[%0d]: got g=%b s=%0d v=%b want g=%b s=%0d v=%b",
                 i, o_Grant, o_Select, o_Valid, e.g, e.s, e.v);
      end
    end
  endtask

  task automatic test_hold;
    exp_t e;
    int   n_hold;
`ifdef MUX_ARB_HOLD_TIMEOUT_EN
    n_hold = 8;
`else
    n_hold = 110;
`endif
    cyc(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < n_hold; i++) sb.push_back('{g: 4'b0001, s: 2'd0, v: 1'b1});
`ifdef MUX_ARB_HOLD_TIMEOUT_EN
    sb.push_back('{g: 4'b0000, s: 2'd0, v: 1'b0});
    sb.push_back('{g: 4'b0010, s: 2'd1, v: 1'b1});
`endif
    for (int i = 0; sb.size() > 0; i++) begin
      cyc(1'b0, 4'b0011, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({o_Grant, o_Select, o_Valid} !== {e.g, e.s, e.v}) begin
        errors++;
        $display("FAIL hold[%0d]: got g=%b s=%0d v=%b want g=%b s=%0d v=%b",
                 i, o_Grant, o_Select, o_Valid, e.g, e.s, e.v);
      end
    end
    cyc(1'b0, 4'b0000, 1'b1);
  endtask

  initial begin
    i_Rst  = 1'b1;
    i_Req  = 4'b0000;
    i_Done = 1'b0;
    test_reset();
    test_first_grant();
    test_round_robin();
    test_owner_drop();
    test_done_idle();
    test_reset_mid_grant();
    test_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
